// File: rtl/d7s_pkg.sv
// rtl/d7s_pkg.sv - shared 7-segment constants, FSM state type and select helper
package d7s_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] DIG_BLANK   = 4'hF;
    localparam logic [3:0] DIG_INVALID = 4'hE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } d7s_state_e;

    function automatic logic is_multi_hot(input logic [2:0] sel);
        return (sel & (sel - 3'd1)) != 3'd0;
    endfunction

endpackage

// File: rtl/d7s_seg_decode.sv
// rtl/d7s_seg_decode.sv - segment pattern to BCD digit with error flag
module d7s_seg_decode
    import d7s_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       err
);

    always_comb begin
        digit = DIG_INVALID;
        err   = 1'b0;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: digit = DIG_BLANK;
            default:   err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/d7s_scan_decoder.sv
// rtl/d7s_scan_decoder.sv - samples a scanned 3-digit display and rebuilds the frame
module d7s_scan_decoder
    import d7s_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  transistor,
    input  logic [6:0]  d7sp,
    output logic [11:0] digits,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stale,
    output logic        sel_err
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    d7s_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [9:0]        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [2:0]        mask_q, mask_d;
    logic [2:0][3:0]   slot_dig_q, slot_dig_d;
    logic [2:0]        slot_err_q, slot_err_d;
    logic [11:0]       digits_q, digits_d;
    logic              frame_valid_q, frame_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              stale_q, stale_d;
    logic              sel_err_q, sel_err_d;

    logic [2:0] sample_sel;
    logic [6:0] sample_seg;
    logic       same, sel_none, sel_multi, sel_one;
    logic       capture, commit, tmo_hit;
    logic [1:0] cap_idx;
    logic [3:0] dec_digit;
    logic       dec_err;

    assign sample_sel = sync2_q[9:7];
    assign sample_seg = sync2_q[6:0];
    assign same       = (sync2_q == prev_q);
    assign sel_none   = (sample_sel == 3'b000);
    assign sel_multi  = is_multi_hot(sample_sel);
    assign sel_one    = !sel_none && !sel_multi;

    d7s_seg_decode u_seg_decode (
        .seg   (sample_seg),
        .digit (dec_digit),
        .err   (dec_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sel_none || sel_multi) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
                SETTLE: begin
                    if (!same) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!same) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Error pulse fires once on entry into a multi-hot select, not every cycle it persists.
    always_comb begin
        capture   = (state_q == SETTLE) && sel_one && same && (cnt_q == CNT_LAST);
        sel_err_d = sel_multi && !is_multi_hot(prev_q[9:7]);
    end

    always_comb begin
        sync1_d = {transistor, d7sp};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cap_idx = sample_sel[2] ? 2'd2 : (sample_sel[1] ? 2'd1 : 2'd0);
        commit  = (mask_q == 3'b111);

        tmo_d = tmo_q;
        if (capture)
            tmo_d = '0;
        else if (tmo_q != TMO_MAX)
            tmo_d = tmo_q + TMO_W'(1);
        tmo_hit = !capture && (tmo_q != TMO_MAX) && (tmo_d == TMO_MAX);

        // Commit reads the registered slots, so a capture landing on the commit cycle opens the next frame.
        mask_d = mask_q;
        if (commit || tmo_hit)
            mask_d = 3'b000;
        if (capture)
            mask_d = mask_d | sample_sel;

        slot_dig_d = slot_dig_q;
        slot_err_d = slot_err_q;
        if (capture) begin
            slot_dig_d[cap_idx] = dec_digit;
            slot_err_d[cap_idx] = dec_err;
        end

        digits_d      = digits_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = 1'b0;
        stale_d       = stale_q;
        if (tmo_hit)
            stale_d = 1'b1;
        if (commit) begin
            digits_d      = slot_dig_q;
            frame_err_d   = |slot_err_q;
            frame_valid_d = 1'b1;
            stale_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            tmo_q         <= '0;
            mask_q        <= '0;
            slot_dig_q    <= {3{DIG_BLANK}};
            slot_err_q    <= '0;
            digits_q      <= 12'hFFF;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            stale_q       <= 1'b1;
            sel_err_q     <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            tmo_q         <= tmo_d;
            mask_q        <= mask_d;
            slot_dig_q    <= slot_dig_d;
            slot_err_q    <= slot_err_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            stale_q       <= stale_d;
            sel_err_q     <= sel_err_d;
        end
    end

    assign digits      = digits_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign stale       = stale_q;
    assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_d7s_scan_decoder.sv
// tb/tb_d7s_scan_decoder.sv - scoreboard bench for d7s_scan_decoder
module tb_d7s_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  transistor = 3'b000;
    logic [6:0]  d7sp = 7'h00;
    logic [11:0] digits;
    logic        frame_valid, frame_err, stale, sel_err;

    typedef struct packed {
        logic [11:0] digits;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   frames_seen = 0;
    int   sel_err_cnt = 0;
    int   sel_err_before;

    d7s_scan_decoder #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .transistor  (transistor),
        .d7sp        (d7sp),
        .digits      (digits),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .stale       (stale),
        .sel_err     (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic [6:0] p, input int n);
        transistor = s;
        d7sp       = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gap();
        drive(3'b000, 7'h00, 2);
    endtask

    task automatic scan3(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h);
        drive(3'b001, u, 8); gap();
        drive(3'b010, t, 8); gap();
        drive(3'b100, h, 8); gap();
    endtask

    task automatic expect_frame(input logic [11:0] d, input logic e);
        exp_t x;
        x.digits = d;
        x.err    = e;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sel_err)
                sel_err_cnt++;
            if (frame_valid) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_valid", {20'h0, digits}, 32'hDEAD);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("frame_digits", {20'h0, digits}, {20'h0, x.digits});
                    check("frame_err", {31'h0, frame_err}, {31'h0, x.err});
                    check("frame_stale", {31'h0, stale}, 32'h0);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", {20'h0, digits}, 32'hFFF);
        check("reset_frame_valid", {31'h0, frame_valid}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);
        check("reset_stale", {31'h0, stale}, 32'h1);
        check("reset_sel_err", {31'h0, sel_err}, 32'h0);
        rst = 1'b0;
        gap();

        expect_frame(12'h210, 1'b0);
        scan3(7'h7E, 7'h30, 7'h6D);
        check("stale_after_first_frame", {31'h0, stale}, 32'h0);

        expect_frame(12'h216, 1'b0);
        drive(3'b001, 7'h7B, 2);
        drive(3'b001, 7'h5F, 6); gap();
        drive(3'b010, 7'h30, 8); gap();
        drive(3'b100, 7'h6D, 8); gap();

        expect_frame(12'h4E0, 1'b1);
        scan3(7'h7E, 7'h01, 7'h33);

        expect_frame(12'h753, 1'b0);
        scan3(7'h79, 7'h5B, 7'h70);

        expect_frame(12'h810, 1'b0);
        drive(3'b001, 7'h7E, 8); gap();
        drive(3'b010, 7'h30, 8); gap();
        sel_err_before = sel_err_cnt;
        drive(3'b011, 7'h7F, 8); gap();
        check("sel_err_pulses", sel_err_cnt - sel_err_before, 32'd1);
        drive(3'b100, 7'h7F, 8); gap();

        drive(3'b001, 7'h7E, 8); gap();
        drive(3'b010, 7'h30, 8);
        drive(3'b000, 7'h00, 70);
        check("stale_after_timeout", {31'h0, stale}, 32'h1);
        check("digits_kept_when_stale", {20'h0, digits}, 32'h810);
        drive(3'b100, 7'h30, 8); gap();
        check("stale_until_commit", {31'h0, stale}, 32'h1);
        expect_frame(12'h186, 1'b0);
        drive(3'b001, 7'h5F, 8); gap();
        drive(3'b010, 7'h7F, 8); gap();
        check("stale_cleared_by_frame", {31'h0, stale}, 32'h0);

        drive(3'b001, 7'h7E, 8); gap();
        drive(3'b010, 7'h30, 8); gap();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_digits", {20'h0, digits}, 32'hFFF);
        check("midreset_stale", {31'h0, stale}, 32'h1);
        drive(3'b100, 7'h6D, 8);
        drive(3'b000, 7'h00, 20);

        check("pending_frames", exp_q.size(), 32'd0);
        check("frames_seen", frames_seen, 32'd6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
